// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
// Holds the default datapath width, the canonical NOP and the fetch FSM states.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register for the fetch stage.
// Loads d_i when en_i is high and returns to RESET_PC on an asynchronous reset.
module pc_reg #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (en_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect handling and the IF/ID register.
// A misaligned redirect locks the stage into FAULT until the next reset.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  output logic [XLEN-1:0] ImemAddr,
  input  logic [XLEN-1:0] ImemRdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchFault
);

  localparam logic [XLEN-1:0] NOP_X   = XLEN'(NOP_INSTR);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pcf;
  logic [XLEN-1:0] pcf_plus4;
  logic [XLEN-1:0] pc_d;
  logic            pc_en;
  logic            bad_redirect;

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic [XLEN-1:0] pcp4_q, pcp4_d;
  logic            valid_q, valid_d;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (pc_en),
    .d_i  (pc_d),
    .q_o  (pcf)
  );

  // Wraps naturally at 2^XLEN; wraparound is not a fault.
  assign pcf_plus4    = pcf + PC_STEP;
  assign bad_redirect = PCSrcE && (PCTargetE[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_en   = 1'b0;
    pc_d    = pcf;
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (bad_redirect) begin
          state_d = FAULT;
          instr_d = NOP_X;
          pcd_d   = '0;
          pcp4_d  = '0;
          valid_d = 1'b0;
        end else begin
          // A redirect always moves the PC, even against a fetch stall.
          pc_en = PCSrcE || !StallF;
          pc_d  = PCSrcE ? PCTargetE : pcf_plus4;
          if (FlushD) begin
            instr_d = NOP_X;
            pcd_d   = '0;
            pcp4_d  = '0;
            valid_d = 1'b0;
          end else if (!StallD) begin
            instr_d = ImemRdata;
            pcd_d   = pcf;
            pcp4_d  = pcf_plus4;
            valid_d = 1'b1;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      instr_q <= NOP_X;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign ImemAddr   = pcf;
  assign InstrD     = instr_q;
  assign PCD        = pcd_q;
  assign PCPlus4D   = pcp4_q;
  assign ValidD     = valid_q;
  assign FetchFault = (state_q == FAULT);

endmodule
